// File: rtl/ex_stage_mdu.sv
// MIPS execute stage: three-source forwarding, ALU, iterative multiply/divide unit with HI/LO,
// and a registered EX/MEM boundary that loads bubbles while the MDU stalls or on a flush.
module ex_stage_mdu #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IDExValid,
  input  logic              IDExFlush,
  input  logic [DATA_W-1:0] IDExReadData1,
  input  logic [DATA_W-1:0] IDExReadData2,
  input  logic [DATA_W-1:0] IDExImm,
  input  logic [REG_AW-1:0] IDExRt,
  input  logic [REG_AW-1:0] IDExRd,
  input  logic [3:0]        AluOp,
  input  logic [1:0]        HiLoSel,
  input  logic              RegDst,
  input  logic              AluSrc,
  input  logic [1:0]        ForwardA,
  input  logic [1:0]        ForwardB,
  input  logic [DATA_W-1:0] FwdMemValue,
  input  logic [DATA_W-1:0] WriteBackValue,
  input  logic              IDExWriteRegEnable,
  input  logic              IDExWriteMemoryEnable,
  input  logic              IDExReadMemoryEnable,
  input  logic              IDExMemToReg,
  output logic              ExStall,
  output logic              ExMemValid,
  output logic [DATA_W-1:0] ExMemAluOut,
  output logic [DATA_W-1:0] ExMemReadData2,
  output logic [REG_AW-1:0] ExMemDest,
  output logic              ExMemWriteRegEnable,
  output logic              ExMemWriteMemoryEnable,
  output logic              ExMemReadMemoryEnable,
  output logic              ExMemMemToReg,
  output logic              ExMemOverflow,
  output logic              o_mdu_state
);
  localparam int SH_W    = $clog2(DATA_W);
  localparam int LAT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} mdu_state_e;

  mdu_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_op_a, r_op_b, r_hi, r_lo;
  logic [1:0]        r_mdu_op;

  logic [DATA_W-1:0] w_fwd_a, w_fwd_b, w_op_b, w_alu_res, w_result, w_sum, w_diff;
  logic              w_ovf, w_is_mdu, w_issue, w_stall, w_done;

  always_comb begin
    w_fwd_a = IDExReadData1;
    case (ForwardA)
      2'b01:   w_fwd_a = FwdMemValue;
      2'b10:   w_fwd_a = WriteBackValue;
      default: w_fwd_a = IDExReadData1;
    endcase
    w_fwd_b = IDExReadData2;
    case (ForwardB)
      2'b01:   w_fwd_b = FwdMemValue;
      2'b10:   w_fwd_b = WriteBackValue;
      default: w_fwd_b = IDExReadData2;
    endcase
  end

  assign w_op_b   = AluSrc ? IDExImm : w_fwd_b;
  assign w_sum    = w_fwd_a + w_op_b;
  assign w_diff   = w_fwd_a - w_op_b;
  assign w_is_mdu = (AluOp[3:2] == 2'b11);

  always_comb begin
    w_alu_res = '0;
    w_ovf     = 1'b0;
    case (AluOp)
      4'b0000: w_alu_res = w_fwd_a & w_op_b;
      4'b0001: w_alu_res = w_fwd_a | w_op_b;
      4'b0010, 4'b0101: begin
        w_alu_res = w_sum;
        w_ovf = (w_fwd_a[DATA_W-1] == w_op_b[DATA_W-1]) && (w_sum[DATA_W-1] != w_fwd_a[DATA_W-1]);
      end
      4'b0011: w_alu_res = w_fwd_a ^ w_op_b;
      4'b0100: w_alu_res = ~(w_fwd_a | w_op_b);
      4'b0110: begin
        w_alu_res = w_diff;
        w_ovf = (w_fwd_a[DATA_W-1] != w_op_b[DATA_W-1]) && (w_diff[DATA_W-1] != w_fwd_a[DATA_W-1]);
      end
      4'b0111: w_alu_res = DATA_W'($signed(w_fwd_a) < $signed(w_op_b));
      4'b1000: w_alu_res = w_fwd_a << w_op_b[SH_W-1:0];
      4'b1001: w_alu_res = w_fwd_a >> w_op_b[SH_W-1:0];
      4'b1010: w_alu_res = DATA_W'($signed(w_fwd_a) >>> w_op_b[SH_W-1:0]);
      4'b1011: w_alu_res = DATA_W'(w_fwd_a < w_op_b);
      default: w_alu_res = '0;
    endcase
  end

  always_comb begin
    case (HiLoSel)
      2'b01:   w_result = r_hi;
      2'b10:   w_result = r_lo;
      default: w_result = w_alu_res;
    endcase
  end

  // MDU datapath works on operands latched at issue, so forwarding may change while busy.
  // Divide runs on magnitudes; MIN/-1 then falls out naturally as LO=MIN, HI=0.
  logic                w_signed, w_neg_a, w_neg_b;
  logic [2*DATA_W-1:0] w_ext_a, w_ext_b, w_prod;
  logic [DATA_W-1:0]   w_mag_a, w_mag_b, w_den, w_uq, w_ur, w_q, w_r, w_mdu_hi, w_mdu_lo;

  always_comb begin
    w_signed = ~r_mdu_op[0];
    w_ext_a  = {{DATA_W{w_signed & r_op_a[DATA_W-1]}}, r_op_a};
    w_ext_b  = {{DATA_W{w_signed & r_op_b[DATA_W-1]}}, r_op_b};
    w_prod   = w_ext_a * w_ext_b;
    w_neg_a  = w_signed & r_op_a[DATA_W-1];
    w_neg_b  = w_signed & r_op_b[DATA_W-1];
    w_mag_a  = w_neg_a ? -r_op_a : r_op_a;
    w_mag_b  = w_neg_b ? -r_op_b : r_op_b;
    w_den    = (r_op_b == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : w_mag_b;
    w_uq     = w_mag_a / w_den;
    w_ur     = w_mag_a % w_den;
    w_q      = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
    w_r      = w_neg_a ? -w_ur : w_ur;
    if (!r_mdu_op[1]) begin
      w_mdu_hi = w_prod[2*DATA_W-1:DATA_W];
      w_mdu_lo = w_prod[DATA_W-1:0];
    end else if (r_op_b == '0) begin
      w_mdu_hi = r_op_a;
      w_mdu_lo = '1;
    end else begin
      w_mdu_hi = w_r;
      w_mdu_lo = w_q;
    end
  end

  // Stall handshake: ExStall=1 means EX does not accept; ID/EX and earlier must hold their
  // contents unchanged, and EX/MEM receives a bubble. ExStall=0 means the current ID/EX
  // instruction (if valid) is consumed at the next rising edge.
  assign w_issue = IDExValid & w_is_mdu & ~IDExFlush;

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (w_issue) begin
        w_state_nxt = S_BUSY;
        w_stall     = 1'b1;
      end
      S_BUSY: begin
        if (IDExFlush) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign ExStall     = w_stall & ~reset;
  assign o_mdu_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_mdu_op <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_issue) begin
        r_op_a   <= w_fwd_a;
        r_op_b   <= w_fwd_b;
        r_mdu_op <= AluOp[1:0];
        r_cnt    <= AluOp[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
      end else if (r_state == S_BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_done) begin
        r_hi <= w_mdu_hi;
        r_lo <= w_mdu_lo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ExMemValid             <= 1'b0;
      ExMemAluOut            <= '0;
      ExMemReadData2         <= '0;
      ExMemDest              <= '0;
      ExMemWriteRegEnable    <= 1'b0;
      ExMemWriteMemoryEnable <= 1'b0;
      ExMemReadMemoryEnable  <= 1'b0;
      ExMemMemToReg          <= 1'b0;
      ExMemOverflow          <= 1'b0;
    end else if (IDExFlush || ExStall) begin
      ExMemValid             <= 1'b0;
      ExMemWriteRegEnable    <= 1'b0;
      ExMemWriteMemoryEnable <= 1'b0;
      ExMemReadMemoryEnable  <= 1'b0;
      ExMemMemToReg          <= 1'b0;
      ExMemOverflow          <= 1'b0;
    end else begin
      ExMemValid             <= IDExValid;
      ExMemAluOut            <= w_result;
      ExMemReadData2         <= w_fwd_b;
      ExMemDest              <= RegDst ? IDExRd : IDExRt;
      ExMemWriteRegEnable    <= IDExWriteRegEnable & IDExValid;
      ExMemWriteMemoryEnable <= IDExWriteMemoryEnable & IDExValid;
      ExMemReadMemoryEnable  <= IDExReadMemoryEnable & IDExValid;
      ExMemMemToReg          <= IDExMemToReg & IDExValid;
      ExMemOverflow          <= w_ovf & IDExValid;
    end
  end
endmodule

// File: tb/tb_ex_stage_mdu.sv
// Bench for ex_stage_mdu: drives instructions, counts stalls, and checks EX/MEM output
// against a scoreboard of expected results plus a HI/LO reference model.
module tb_ex_stage_mdu;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          IDExValid, IDExFlush, RegDst, AluSrc;
  logic [DW-1:0] IDExReadData1, IDExReadData2, IDExImm, FwdMemValue, WriteBackValue;
  logic [4:0]    IDExRt, IDExRd;
  logic [3:0]    AluOp;
  logic [1:0]    HiLoSel, ForwardA, ForwardB;
  logic          IDExWriteRegEnable, IDExWriteMemoryEnable, IDExReadMemoryEnable, IDExMemToReg;
  logic          ExStall, ExMemValid, ExMemOverflow, o_mdu_state;
  logic [DW-1:0] ExMemAluOut, ExMemReadData2;
  logic [4:0]    ExMemDest;
  logic          ExMemWriteRegEnable, ExMemWriteMemoryEnable, ExMemReadMemoryEnable, ExMemMemToReg;

  ex_stage_mdu dut (
    .clk(clk), .reset(reset), .IDExValid(IDExValid), .IDExFlush(IDExFlush),
    .IDExReadData1(IDExReadData1), .IDExReadData2(IDExReadData2), .IDExImm(IDExImm),
    .IDExRt(IDExRt), .IDExRd(IDExRd), .AluOp(AluOp), .HiLoSel(HiLoSel), .RegDst(RegDst),
    .AluSrc(AluSrc), .ForwardA(ForwardA), .ForwardB(ForwardB), .FwdMemValue(FwdMemValue),
    .WriteBackValue(WriteBackValue), .IDExWriteRegEnable(IDExWriteRegEnable),
    .IDExWriteMemoryEnable(IDExWriteMemoryEnable), .IDExReadMemoryEnable(IDExReadMemoryEnable),
    .IDExMemToReg(IDExMemToReg), .ExStall(ExStall), .ExMemValid(ExMemValid),
    .ExMemAluOut(ExMemAluOut), .ExMemReadData2(ExMemReadData2), .ExMemDest(ExMemDest),
    .ExMemWriteRegEnable(ExMemWriteRegEnable), .ExMemWriteMemoryEnable(ExMemWriteMemoryEnable),
    .ExMemReadMemoryEnable(ExMemReadMemoryEnable), .ExMemMemToReg(ExMemMemToReg),
    .ExMemOverflow(ExMemOverflow), .o_mdu_state(o_mdu_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rd2_q[$];
  logic [4:0]    exp_dest_q[$];
  logic [3:0]    exp_ctl_q[$];
  logic          exp_ov_q[$];
  logic          exp_care_q[$];

  logic [DW-1:0] m_hi, m_lo;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fwd_val(input logic [1:0] code, input logic [DW-1:0] rd,
                                            input logic [DW-1:0] fm, input logic [DW-1:0] wb);
    if (code == 2'b01) return fm;
    if (code == 2'b10) return wb;
    return rd;
  endfunction

  // ALU reference: overflow derived from a wide signed sum rather than sign bits
  function automatic logic [DW:0] alu_model(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    longint   t;
    logic [DW-1:0] r;
    logic     ov;
    r = '0; ov = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2, 4'd5: begin
        t = longint'($signed(a)) + longint'($signed(b));
        r = a + b; ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd3: r = a ^ b;
      4'd4: r = ~(a | b);
      4'd6: begin
        t = longint'($signed(a)) - longint'($signed(b));
        r = a - b; ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8: r = a << b[4:0];
      4'd9: r = a >> b[4:0];
      4'd10: r = $signed(a) >>> b[4:0];
      4'd11: r = (a < b) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return {ov, r};
  endfunction

  // scoreboard: pop and compare whenever EX/MEM presents a valid instruction
  task automatic sb_check();
    logic [DW-1:0] e, e_rd2; logic [4:0] e_dest; logic [3:0] e_ctl; logic e_ov, e_care;
    check_eq("exmem_valid", ExMemValid, 1);
    if (ExMemValid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_underflow: got output 0x%08h expected none", ExMemAluOut);
      end else begin
        e = exp_q.pop_front(); e_rd2 = exp_rd2_q.pop_front(); e_dest = exp_dest_q.pop_front();
        e_ctl = exp_ctl_q.pop_front(); e_ov = exp_ov_q.pop_front(); e_care = exp_care_q.pop_front();
        if (e_care) begin
          check_eq("alu_out", ExMemAluOut, e);
          check_eq("overflow", ExMemOverflow, e_ov);
        end
        check_eq("read_data2", ExMemReadData2, e_rd2);
        check_eq("dest", ExMemDest, e_dest);
        check_eq("controls", {ExMemWriteRegEnable, ExMemWriteMemoryEnable,
                              ExMemReadMemoryEnable, ExMemMemToReg}, e_ctl);
      end
    end
  endtask

  // driver: present one instruction, count stall cycles, then check the EX/MEM result
  task automatic run_op(input logic [3:0] op, input logic [1:0] hls, input logic [DW-1:0] rd1,
                        input logic [DW-1:0] rd2, input logic [DW-1:0] imm, input logic asrc,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [DW-1:0] fm,
                        input logic [DW-1:0] wb, input int exp_stall, input logic care,
                        input logic [DW-1:0] exp_val, input logic exp_ov);
    int stalls;
    logic [3:0] ctl;
    ctl = 4'($urandom_range(0, 15));
    IDExValid = 1'b1; IDExFlush = 1'b0; AluOp = op; HiLoSel = hls;
    IDExReadData1 = rd1; IDExReadData2 = rd2; IDExImm = imm; AluSrc = asrc;
    ForwardA = fa; ForwardB = fb; FwdMemValue = fm; WriteBackValue = wb;
    IDExRt = 5'($urandom_range(0, 31)); IDExRd = 5'($urandom_range(0, 31));
    RegDst = 1'($urandom_range(0, 1));
    {IDExWriteRegEnable, IDExWriteMemoryEnable, IDExReadMemoryEnable, IDExMemToReg} = ctl;
    stalls = 0;
    #1;
    while (ExStall && stalls < 200) begin
      stalls++;
      @(posedge clk); @(negedge clk); #1;
      check_eq("stall_bubble", {ExMemValid, ExMemWriteRegEnable}, 0);
    end
    check_eq("stall_cycles", stalls, exp_stall);
    exp_q.push_back(exp_val);
    exp_rd2_q.push_back(fwd_val(fb, rd2, fm, wb));
    exp_dest_q.push_back(RegDst ? IDExRd : IDExRt);
    exp_ctl_q.push_back(ctl);
    exp_ov_q.push_back(exp_ov);
    exp_care_q.push_back(care);
    @(posedge clk); @(negedge clk);
    sb_check();
  endtask

  task automatic read_hilo();
    run_op(4'd0, 2'b01, 0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 0, 0, 1'b1, m_hi, 1'b0);
    run_op(4'd0, 2'b10, 0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 0, 0, 1'b1, m_lo, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a, b, imm, fm, wb, fa_v, fb_v;
    logic [1:0] fa, fb;
    logic [3:0] op;
    logic asrc;
    logic [DW:0] r;
    longint p;

    reset = 1'b1; IDExValid = 0; IDExFlush = 0; IDExReadData1 = 0; IDExReadData2 = 0;
    IDExImm = 0; IDExRt = 0; IDExRd = 0; AluOp = 0; HiLoSel = 0; RegDst = 0; AluSrc = 0;
    ForwardA = 0; ForwardB = 0; FwdMemValue = 0; WriteBackValue = 0;
    IDExWriteRegEnable = 0; IDExWriteMemoryEnable = 0; IDExReadMemoryEnable = 0; IDExMemToReg = 0;
    m_hi = 0; m_lo = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", ExMemValid, 0);
    check_eq("rst_alu", ExMemAluOut, 0);
    check_eq("rst_stall", ExStall, 0);
    check_eq("rst_ctl", {ExMemWriteRegEnable, ExMemWriteMemoryEnable, ExMemReadMemoryEnable,
                         ExMemMemToReg, ExMemOverflow}, 0);
    reset = 1'b0;
    read_hilo();

    run_op(4'b0010, 2'b00, 32'h7FFF_FFFF, 32'h1, 0, 1'b0, 2'b00, 2'b00, 0, 0, 0, 1'b1, 32'h8000_0000, 1'b1);
    run_op(4'b0110, 2'b00, 32'd100, 32'd200, 0, 1'b0, 2'b01, 2'b10, 32'd5, 32'd3, 0, 1'b1, 32'd2, 1'b0);
    run_op(4'b0110, 2'b00, 32'd10, 32'd200, 0, 1'b0, 2'b11, 2'b10, 32'd5, 32'd3, 0, 1'b1, 32'd7, 1'b0);
    run_op(4'b0010, 2'b00, 32'd4, 32'd99, 32'hFFFF_FFFF, 1'b1, 2'b00, 2'b00, 0, 0, 0, 1'b1, 32'd3, 1'b0);

    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 11));
      a = $urandom; b = $urandom; imm = $urandom; fm = $urandom; wb = $urandom;
      fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3)); asrc = 1'($urandom_range(0, 1));
      fa_v = fwd_val(fa, a, fm, wb); fb_v = fwd_val(fb, b, fm, wb);
      r = alu_model(op, fa_v, asrc ? imm : fb_v);
      run_op(op, 2'b00, a, b, imm, asrc, fa, fb, fm, wb, 0, 1'b1, r[DW-1:0], r[DW]);
    end

    run_op(4'b1100, 2'b00, 32'hFFFF_FFFD, 32'd7, 0, 1'b0, 2'b00, 2'b00, 0, 0, 4, 1'b0, 0, 1'b0);
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFEB;
    read_hilo();
    run_op(4'b1110, 2'b00, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 2'b00, 2'b00, 0, 0, 32, 1'b0, 0, 1'b0);
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFD;
    read_hilo();
    run_op(4'b1111, 2'b00, 0, 0, 0, 1'b0, 2'b01, 2'b10, 32'd9, 32'd0, 32, 1'b0, 0, 1'b0);
    m_hi = 32'd9; m_lo = 32'hFFFF_FFFF;
    read_hilo();
    run_op(4'b1110, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 2'b00, 2'b00, 0, 0, 32, 1'b0, 0, 1'b0);
    m_hi = 32'd0; m_lo = 32'h8000_0000;
    read_hilo();

    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      if (i[0] == 1'b0) begin
        p = longint'($signed(a)) * longint'($signed(b));
        run_op(4'b1100, 2'b00, a, b, 0, 1'b0, 2'b00, 2'b00, 0, 0, 4, 1'b0, 0, 1'b0);
        m_hi = p[63:32]; m_lo = p[31:0];
      end else begin
        b = $urandom_range(1, 1000);
        run_op(4'b1111, 2'b00, a, b, 0, 1'b0, 2'b00, 2'b00, 0, 0, 32, 1'b0, 0, 1'b0);
        m_hi = a % b; m_lo = a / b;
      end
      read_hilo();
    end

    // MULTU aborted by a flush in its second stall cycle; HI/LO must survive
    IDExValid = 1'b1; AluOp = 4'b1101; HiLoSel = 2'b00; IDExReadData1 = 32'd5;
    IDExReadData2 = 32'd6; ForwardA = 2'b00; ForwardB = 2'b00; AluSrc = 1'b0;
    #1 check_eq("flush_issue_stall", ExStall, 1);
    @(posedge clk); @(negedge clk); #1;
    check_eq("flush_cyc2_stall", ExStall, 1);
    check_eq("flush_cyc2_bubble", ExMemValid, 0);
    IDExFlush = 1'b1;
    #1 check_eq("flush_stall_drop", ExStall, 0);
    @(posedge clk); @(negedge clk);
    check_eq("flush_bubble", ExMemValid, 0);
    check_eq("flush_fsm_idle", o_mdu_state, 0);
    IDExFlush = 1'b0;
    read_hilo();

    // reset in the middle of a DIV
    IDExValid = 1'b1; AluOp = 4'b1110; HiLoSel = 2'b00; IDExReadData1 = 32'd1000;
    IDExReadData2 = 32'd7; IDExWriteRegEnable = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    check_eq("midrst_stall", ExStall, 0);
    check_eq("midrst_fsm", o_mdu_state, 0);
    check_eq("midrst_alu", ExMemAluOut, 0);
    check_eq("midrst_rd2", ExMemReadData2, 0);
    check_eq("midrst_ctl", {ExMemValid, ExMemWriteRegEnable, ExMemWriteMemoryEnable,
                            ExMemReadMemoryEnable, ExMemMemToReg, ExMemOverflow}, 0);
    reset = 1'b0;
    m_hi = 0; m_lo = 0;
    read_hilo();

    IDExValid = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("sb_leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
